// File: rtl/mem_access_unit_if.sv
// Data-side SRAM-like bus between the MEM-stage access engine and the dcache.
// The master drives the request side; the slave answers with addr_ok/data_ok/rdata.
interface mem_access_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [3:0]        data_wstrb;
    logic [DATA_W-1:0] data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [DATA_W-1:0] data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wstrb, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: one req/addr_ok/data_ok transaction per access, AdEL/AdES, stall.
// Optional macro LOAD_DATA_REG_EN registers the extended load result (one extra cycle of latency).
module mem_access_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              valid_i,
    input  logic              flush_i,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic [2:0]        mem_type_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    mem_access_unit_if.master dbus,
    output logic              stall_o,
    output logic              done_o,
    output logic [DATA_W-1:0] load_data_o,
    output logic              adel_o,
    output logic              ades_o,
    output logic [ADDR_W-1:0] bad_vaddr_o
);
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN, S_RESP} state_e;

    state_e state_q, state_d;
    logic   is_acc, live, aligned, start, misalign, req, done;

    function automatic logic [31:0] ext_load(input logic [31:0] rd, input logic [2:0] t,
                                             input logic [1:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = a[1] ? rd[31:16] : rd[15:0];
        case (t[1:0])
            2'b00:   ext_load = {{24{t[2] & b[7]}}, b};
            2'b01:   ext_load = {{16{t[2] & h[15]}}, h};
            default: ext_load = rd;
        endcase
    endfunction

    assign live    = aresetn & valid_i & ~flush_i;
    assign is_acc  = (mem_read_i | mem_write_i) & (mem_type_i != 3'b111);
    // Size 2'b11 is not a legal encoding; it is checked like a word.
    assign aligned = (mem_type_i[1:0] == 2'b00) ? 1'b1 :
                     (mem_type_i[1:0] == 2'b01) ? ~addr_i[0] : (addr_i[1:0] == 2'b00);
    assign start    = live & is_acc & aligned;
    assign misalign = live & is_acc & ~aligned;

    assign adel_o      = misalign & ~mem_write_i;
    assign ades_o      = misalign & mem_write_i;
    assign bad_vaddr_o = misalign ? addr_i : '0;

    always_comb begin
        state_d = state_q;
        req     = 1'b0;
        done    = 1'b0;
        stall_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                req     = start;
                stall_o = start;
                if (start) state_d = dbus.data_addr_ok ? S_WAIT : S_REQ;
            end
            S_REQ: begin
                req     = ~flush_i;
                stall_o = 1'b1;
                if (flush_i)                state_d = S_IDLE;
                else if (dbus.data_addr_ok) state_d = S_WAIT;
            end
            S_WAIT: begin
`ifdef LOAD_DATA_REG_EN
                stall_o = 1'b1;
                if (dbus.data_data_ok) state_d = flush_i ? S_IDLE : S_RESP;
                else if (flush_i)      state_d = S_DRAIN;
`else
                done    = dbus.data_data_ok & ~flush_i;
                stall_o = ~done;
                if (dbus.data_data_ok) state_d = S_IDLE;
                else if (flush_i)      state_d = S_DRAIN;
`endif
            end
            S_DRAIN: begin
                stall_o = valid_i & (mem_read_i | mem_write_i);
                if (dbus.data_data_ok) state_d = S_IDLE;
            end
            S_RESP: begin
                done    = ~flush_i;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (!aresetn) begin
            req     = 1'b0;
            done    = 1'b0;
            stall_o = 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

`ifdef LOAD_DATA_REG_EN
    logic [DATA_W-1:0] load_q;
    always_ff @(posedge aclk) begin
        if (!aresetn)
            load_q <= '0;
        else if (state_q == S_WAIT && dbus.data_data_ok)
            load_q <= ext_load(dbus.data_rdata, mem_type_i, addr_i[1:0]);
    end
    assign load_data_o = done ? load_q : '0;
`else
    assign load_data_o = done ? ext_load(dbus.data_rdata, mem_type_i, addr_i[1:0]) : '0;
`endif

    assign done_o = done;

    // Bus fields follow the live inputs; the dcache only samples them while data_req is high.
    assign dbus.data_req   = req;
    assign dbus.data_wr    = mem_write_i;
    assign dbus.data_size  = mem_type_i[1:0];
    assign dbus.data_addr  = addr_i;
    always_comb begin
        dbus.data_wstrb = 4'b0000;
        dbus.data_wdata = wdata_i;
        if (mem_write_i) begin
            case (mem_type_i[1:0])
                2'b00: begin
                    dbus.data_wstrb = 4'b0001 << addr_i[1:0];
                    dbus.data_wdata = {4{wdata_i[7:0]}};
                end
                2'b01: begin
                    dbus.data_wstrb = addr_i[1] ? 4'b1100 : 4'b0011;
                    dbus.data_wdata = {2{wdata_i[15:0]}};
                end
                default: dbus.data_wstrb = 4'b1111;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed plus randomized bench for mem_access_unit against a byte-arithmetic reference model.
module tb_mem_access_unit;
    logic        aclk = 1'b0;
    logic        aresetn;
    logic        valid, flush, mem_read, mem_write;
    logic [2:0]  mem_type;
    logic [31:0] addr, wdata;
    logic        stall, done, adel, ades;
    logic [31:0] load_data, bad_vaddr;
    int          n_chk = 0;
    int          n_fail = 0;

    mem_access_unit_if #(.ADDR_W(32), .DATA_W(32)) dbus ();

    mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .aclk(aclk), .aresetn(aresetn), .valid_i(valid), .flush_i(flush),
        .mem_read_i(mem_read), .mem_write_i(mem_write), .mem_type_i(mem_type),
        .addr_i(addr), .wdata_i(wdata), .dbus(dbus), .stall_o(stall), .done_o(done),
        .load_data_o(load_data), .adel_o(adel), .ades_o(ades), .bad_vaddr_o(bad_vaddr)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: access of n bytes, where n = 2**size.
    function automatic int nbytes(input logic [2:0] t);
        return 1 << t[1:0];
    endfunction
    function automatic logic [3:0] m_strb(input logic [2:0] t, input logic [31:0] a);
        int n = nbytes(t);
        return 4'(((1 << n) - 1) << (a % 4));
    endfunction
    function automatic logic [31:0] m_wdata(input logic [2:0] t, input logic [31:0] wd);
        logic [31:0] r = 0;
        int n = nbytes(t);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
        return r;
    endfunction
    function automatic logic [31:0] m_load(input logic [2:0] t, input logic [31:0] a,
                                           input logic [31:0] rd);
        int n = nbytes(t);
        longint unsigned v = (64'(rd) >> (8 * (a % 4))) & ((64'd1 << (8 * n)) - 1);
        if (t[2] && n < 4 && v >= (64'd1 << (8 * n - 1))) v = v + (64'd1 << 32) - (64'd1 << (8 * n));
        return v[31:0];
    endfunction

    task automatic idle_inputs();
        valid = 0; flush = 0; mem_read = 0; mem_write = 0; mem_type = 3'b010;
        dbus.data_addr_ok = 0; dbus.data_data_ok = 0;
    endtask

    // One aligned access: addr_ok after aok cycles, data_ok dok cycles after acceptance.
    task automatic access(input bit w, input logic [2:0] t, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd, input int aok, input int dok);
        valid = 1; flush = 0; mem_read = ~w; mem_write = w; mem_type = t; addr = a; wdata = wd;
        for (int c = 0; c <= aok; c++) begin
            dbus.data_addr_ok = (c == aok); dbus.data_data_ok = 0;
            @(negedge aclk);
            chk("req_issue", dbus.data_req, 1);
            chk("stall_req", stall, 1);
            if (c == 0) begin
                chk("wstrb", dbus.data_wstrb, w ? m_strb(t, a) : 4'b0);
                if (w) chk("wdata", dbus.data_wdata, m_wdata(t, wd));
                chk("wr", dbus.data_wr, w);
                chk("daddr", dbus.data_addr, a);
            end
            @(posedge aclk); #1;
        end
        dbus.data_addr_ok = 0;
        for (int c = 1; c <= dok; c++) begin
            dbus.data_data_ok = (c == dok);
            dbus.data_rdata = (c == dok) ? rd : $urandom;
            @(negedge aclk);
            chk("req_wait", dbus.data_req, 0);
            chk("done", done, c == dok);
            chk("stall_wait", stall, c != dok);
            if (c == dok && !w) chk("load_data", load_data, m_load(t, a, rd));
            @(posedge aclk); #1;
        end
        idle_inputs();
    endtask

    task automatic misaligned(input bit w, input logic [2:0] t, input logic [31:0] a);
        valid = 1; mem_read = ~w; mem_write = w; mem_type = t; addr = a;
        @(negedge aclk);
        chk("adel", adel, !w);
        chk("ades", ades, w);
        chk("bad_vaddr", bad_vaddr, a);
        chk("req_misal", dbus.data_req, 0);
        chk("stall_misal", stall, 0);
        @(posedge aclk); #1;
        idle_inputs();
    endtask

    initial begin
        logic [2:0] ltypes [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        idle_inputs();
        aresetn = 0; addr = 32'h8000_0010; wdata = 0; dbus.data_rdata = 0;
        valid = 1; mem_read = 1;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        chk("rst_req", dbus.data_req, 0);
        chk("rst_stall", stall, 0);
        chk("rst_done", done, 0);
        @(posedge aclk); #1;
        aresetn = 1; idle_inputs();
        @(negedge aclk);
        chk("idle_stall", stall, 0);
        @(posedge aclk); #1;

        access(0, 3'b010, 32'h8000_0010, 0, 32'hDEAD_BEEF, 0, 1);
        access(0, 3'b100, 32'h8000_0003, 0, 32'h80FF_FFFF, 0, 1);
        access(0, 3'b000, 32'h8000_0003, 0, 32'h80FF_FFFF, 0, 1);
        access(0, 3'b101, 32'h8000_0002, 0, 32'h8001_0000, 0, 1);
        access(1, 3'b000, 32'h8000_0001, 32'h1234_56AB, 0, 0, 1);
        access(1, 3'b001, 32'h8000_0002, 32'h1234_56AB, 0, 0, 2);
        misaligned(0, 3'b010, 32'h8000_0002);
        misaligned(1, 3'b001, 32'h8000_0001);
        access(0, 3'b010, 32'h8000_0020, 0, 32'hCAFE_F00D, 3, 1);

        // No-access encoding: nothing issued, nothing stalled.
        valid = 1; mem_read = 1; mem_type = 3'b111; addr = 32'h8000_0001;
        @(negedge aclk);
        chk("noacc_req", dbus.data_req, 0);
        chk("noacc_adel", adel, 0);
        chk("noacc_stall", stall, 0);
        @(posedge aclk); #1; idle_inputs();

        // Flush in WAIT: drain the late data_ok, then the next load issues.
        valid = 1; mem_read = 1; mem_type = 3'b010; addr = 32'h8000_0040; dbus.data_addr_ok = 1;
        @(posedge aclk); #1;
        dbus.data_addr_ok = 0; flush = 1;
        @(negedge aclk);
        chk("flush_done", done, 0);
        @(posedge aclk); #1;
        flush = 0; addr = 32'h8000_0044;
        for (int c = 0; c < 2; c++) begin
            dbus.data_data_ok = (c == 1); dbus.data_rdata = 32'h1111_1111;
            @(negedge aclk);
            chk("drain_req", dbus.data_req, 0);
            chk("drain_done", done, 0);
            chk("drain_stall", stall, 1);
            @(posedge aclk); #1;
        end
        idle_inputs();
        access(0, 3'b010, 32'h8000_0044, 0, 32'h2222_3333, 0, 1);

        // Flush while REQ waits for addr_ok drops the request.
        valid = 1; mem_write = 1; mem_type = 3'b010; addr = 32'h8000_0050;
        @(posedge aclk); #1;
        flush = 1;
        @(negedge aclk);
        chk("reqflush_req", dbus.data_req, 0);
        @(posedge aclk); #1;
        idle_inputs();
        @(negedge aclk);
        chk("reqflush_idle", stall, 0);
        @(posedge aclk); #1;

        for (int i = 0; i < 60; i++) begin
            bit          w  = 1'($urandom_range(0, 1));
            logic [2:0]  t  = w ? 3'($urandom_range(0, 2)) : ltypes[$urandom_range(0, 4)];
            logic [31:0] a  = $urandom;
            if (a % nbytes(t) != 0) misaligned(w, t, a);
            else access(w, t, a, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(1, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
